// File: rtl/phase_checker_pkg.sv
// Purpose: shared types and constants for the pipeline phase checker.
// Contents: phase encoding enum, FSM state enum, err_code values,
//           retire counter width and the phase successor function.
package phase_pkg;

    localparam int unsigned RETIRE_W = 16;
    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned STROBE_W = 5;

    typedef enum logic [PHASE_W-1:0] {
        PH_IF   = 3'd0,
        PH_ID   = 3'd1,
        PH_EX   = 3'd2,
        PH_MEM  = 3'd3,
        PH_WB   = 3'd4,
        PH_NONE = 3'd7
    } phase_e;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_ORDER  = 2'b10;
    localparam logic [1:0] ERR_AGAIN  = 2'b11;

    // Phase that must follow p in a legal sequence.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_IF:   next_phase = PH_ID;
            PH_ID:   next_phase = PH_EX;
            PH_EX:   next_phase = PH_MEM;
            PH_MEM:  next_phase = PH_WB;
            PH_WB:   next_phase = PH_IF;
            default: next_phase = PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_checker_if.sv
// Purpose: bundle of phase strobes, clear request and checker status.
// Signals: IF/ID/EX/MEM/WB strobes, clr_err (sequencer -> checker);
//          phase_idx, synced, retire_cnt, retire_wrap, err, err_code
//          (checker -> observer).
// Modports: master = sequencer/observer side, slave = checker side.
interface phase_checker_if;

    logic                          IF;
    logic                          ID;
    logic                          EX;
    logic                          MEM;
    logic                          WB;
    logic                          clr_err;
    logic [phase_pkg::PHASE_W-1:0] phase_idx;
    logic                          synced;
    logic [phase_pkg::RETIRE_W-1:0] retire_cnt;
    logic                          retire_wrap;
    logic                          err;
    logic [1:0]                    err_code;

    modport master (
        output IF, ID, EX, MEM, WB, clr_err,
        input  phase_idx, synced, retire_cnt, retire_wrap, err, err_code
    );

    modport slave (
        input  IF, ID, EX, MEM, WB, clr_err,
        output phase_idx, synced, retire_cnt, retire_wrap, err, err_code
    );

endinterface

// File: rtl/phase_checker_onehot_enc.sv
// Purpose: combinational one-hot check and index encoder for the strobes.
// Ports: i_vec     - strobe vector, bit 0 = IF .. bit 4 = WB
//        o_idx_c   - index of the single set bit, PH_NONE otherwise
//        o_valid_c - exactly one bit set
module onehot_enc
    import phase_pkg::*;
(
    input  logic [STROBE_W-1:0] i_vec,
    output logic [PHASE_W-1:0]  o_idx_c,
    output logic                o_valid_c
);

    logic [PHASE_W-1:0] w_idx;

    // Last set bit wins; only meaningful when the vector is one-hot.
    always_comb begin
        w_idx = PHASE_W'(PH_NONE);
        for (int i = 0; i < int'(STROBE_W); i++) begin
            if (i_vec[i]) begin
                w_idx = PHASE_W'(i);
            end
        end
    end

    assign o_valid_c = $onehot(i_vec);
    assign o_idx_c   = o_valid_c ? w_idx : PHASE_W'(PH_NONE);

endmodule

// File: rtl/phase_checker.sv
// Purpose: checks that phase strobes follow IF->ID->EX->MEM->WB->IF,
//          counts in-sequence WB phases and keeps a sticky error status.
// Ports: clk   - clock, all state on rising edge
//        reset - synchronous active-high reset
//        bus   - phase_checker_if slave: strobes and clr_err in,
//                registered phase_idx/synced/retire_cnt/retire_wrap/
//                err/err_code out
module phase_checker
    import phase_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    phase_checker_if.slave bus
);

    logic [STROBE_W-1:0] w_vec;
    logic [PHASE_W-1:0]  w_idx;
    logic                w_valid;

    state_e              r_state;
    state_e              w_state_nxt;
    phase_e              r_last;
    phase_e              w_last_nxt;
    logic                w_err_det;
    logic [1:0]          w_err_kind;
    logic                w_retire;

    logic [PHASE_W-1:0]  r_pidx;
    logic                r_err;
    logic                w_err_nxt;
    logic [1:0]          r_code;
    logic [1:0]          w_code_nxt;
    logic [RETIRE_W-1:0] r_cnt;
    logic [RETIRE_W-1:0] w_cnt_nxt;
    logic                r_wrap;
    logic                w_wrap_nxt;

    assign w_vec = {bus.WB, bus.MEM, bus.EX, bus.ID, bus.IF};

    onehot_enc u_enc (
        .i_vec     (w_vec),
        .o_idx_c   (w_idx),
        .o_valid_c (w_valid)
    );

    // State register; r_last is only meaningful while locked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_HUNT;
            r_last  <= PH_IF;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state, error detection and retire qualification.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_err_det   = 1'b0;
        w_err_kind  = ERR_NONE;
        w_retire    = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_valid && (w_idx == PHASE_W'(PH_IF))) begin
                    w_state_nxt = ST_LOCK;
                    w_last_nxt  = PH_IF;
                end
            end
            ST_LOCK: begin
                if (!w_valid) begin
                    w_err_det   = 1'b1;
                    w_err_kind  = ERR_ONEHOT;
                    w_state_nxt = ST_HUNT;
                end else if (w_idx != PHASE_W'(next_phase(r_last))) begin
                    w_err_det   = 1'b1;
                    w_err_kind  = ERR_ORDER;
                    w_state_nxt = ST_HUNT;
                end else begin
                    w_last_nxt = phase_e'(w_idx);
                    w_retire   = (w_idx == PHASE_W'(PH_WB));
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Next values for error status and retire counter; a new error beats clr_err.
    always_comb begin
        w_err_nxt  = r_err;
        w_code_nxt = r_code;
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (w_err_det) begin
            w_err_nxt  = 1'b1;
            w_code_nxt = (r_err && !bus.clr_err) ? ERR_AGAIN : w_err_kind;
        end else if (bus.clr_err) begin
            w_err_nxt  = 1'b0;
            w_code_nxt = ERR_NONE;
        end
        if (w_retire) begin
            w_cnt_nxt  = r_cnt + RETIRE_W'(1);
            w_wrap_nxt = (r_cnt == {RETIRE_W{1'b1}});
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pidx <= PHASE_W'(PH_NONE);
            r_err  <= 1'b0;
            r_code <= ERR_NONE;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_pidx <= w_idx;
            r_err  <= w_err_nxt;
            r_code <= w_code_nxt;
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.phase_idx   = r_pidx;
    assign bus.synced      = (r_state == ST_LOCK);
    assign bus.retire_cnt  = r_cnt;
    assign bus.retire_wrap = r_wrap;
    assign bus.err         = r_err;
    assign bus.err_code    = r_code;

endmodule

// File: tb/tb_phase_checker.sv
// Purpose: directed self-checking bench for phase_checker.
// Observed/expected words are packed as
// {synced, phase_idx[2:0], err, err_code[1:0], retire_wrap, retire_cnt[15:0]}.
module tb_phase_checker;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    phase_checker_if bus ();

    phase_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive {reset, clr_err, strobes[4:0]} for one cycle, then settle past the edge.
    task automatic step(input logic [6:0] s);
        reset       = s[6];
        bus.clr_err = s[5];
        bus.WB      = s[4];
        bus.MEM     = s[3];
        bus.EX      = s[2];
        bus.ID      = s[1];
        bus.IF      = s[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0]  stim [6] = '{7'h41, 7'h02, 7'h01, 7'h00, 7'h41, 7'h02};
        logic [23:0] expv [6] = '{
            {1'b0, 3'd7, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b0, 3'd1, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b0, 3'd7, 1'b1, 2'b01, 1'b0, 16'd0},
            {1'b0, 3'd7, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b0, 3'd1, 1'b0, 2'b00, 1'b0, 16'd0}};
        logic [23:0] obs;
        for (int k = 0; k < 6; k++) begin
            step(stim[k]);
            obs = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h want %h", k, obs, expv[k]);
            end
        end
    endtask

    task automatic test_legal();
        logic [23:0] obs;
        logic [23:0] exp_w;
        for (int k = 0; k < 15; k++) begin
            step({2'b00, 5'(1 << (k % 5))});
            obs   = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            exp_w = {1'b1, 3'(k % 5), 1'b0, 2'b00, 1'b0, 16'((k + 1) / 5)};
            n_tests++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL legal step %0d: got %h want %h", k, obs, exp_w);
            end
        end
    endtask

    task automatic test_out_of_order();
        logic [6:0]  stim [7] = '{7'h01, 7'h02, 7'h08, 7'h04, 7'h10, 7'h01, 7'h22};
        logic [23:0] expv [7] = '{
            {1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 16'd3},
            {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 16'd3},
            {1'b0, 3'd3, 1'b1, 2'b10, 1'b0, 16'd3},
            {1'b0, 3'd2, 1'b1, 2'b10, 1'b0, 16'd3},
            {1'b0, 3'd4, 1'b1, 2'b10, 1'b0, 16'd3},
            {1'b1, 3'd0, 1'b1, 2'b10, 1'b0, 16'd3},
            {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 16'd3}};
        logic [23:0] obs;
        for (int k = 0; k < 7; k++) begin
            step(stim[k]);
            obs = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL order step %0d: got %h want %h", k, obs, expv[k]);
            end
        end
    endtask

    task automatic test_multi_hot();
        logic [6:0]  stim [4] = '{7'h03, 7'h01, 7'h04, 7'h20};
        logic [23:0] expv [4] = '{
            {1'b0, 3'd7, 1'b1, 2'b01, 1'b0, 16'd3},
            {1'b1, 3'd0, 1'b1, 2'b01, 1'b0, 16'd3},
            {1'b0, 3'd2, 1'b1, 2'b11, 1'b0, 16'd3},
            {1'b0, 3'd7, 1'b0, 2'b00, 1'b0, 16'd3}};
        logic [23:0] obs;
        for (int k = 0; k < 4; k++) begin
            step(stim[k]);
            obs = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL multihot step %0d: got %h want %h", k, obs, expv[k]);
            end
        end
    endtask

    task automatic test_clr_collision();
        logic [6:0]  stim [6] = '{7'h01, 7'h02, 7'h00, 7'h01, 7'h20, 7'h20};
        logic [23:0] expv [6] = '{
            {1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 16'd3},
            {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 16'd3},
            {1'b0, 3'd7, 1'b1, 2'b01, 1'b0, 16'd3},
            {1'b1, 3'd0, 1'b1, 2'b01, 1'b0, 16'd3},
            {1'b0, 3'd7, 1'b1, 2'b01, 1'b0, 16'd3},
            {1'b0, 3'd7, 1'b0, 2'b00, 1'b0, 16'd3}};
        logic [23:0] obs;
        for (int k = 0; k < 6; k++) begin
            step(stim[k]);
            obs = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL clr step %0d: got %h want %h", k, obs, expv[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int          wraps_seen;
        logic [23:0] obs;
        logic [23:0] exp_w;
        logic [15:0] base;
        wraps_seen = 0;
        step(7'h40);
        for (int n = 0; n < 65534; n++) begin
            for (int p = 0; p < 5; p++) begin
                step({2'b00, 5'(1 << p)});
                if (bus.retire_wrap === 1'b1) wraps_seen++;
            end
        end
        n_tests++;
        if (bus.retire_cnt !== 16'hFFFE || wraps_seen != 0) begin
            n_fail++;
            $display("FAIL wrap preload: got cnt=%h wraps=%0d want cnt=fffe wraps=0",
                     bus.retire_cnt, wraps_seen);
        end
        for (int k = 0; k < 11; k++) begin
            step({2'b00, 5'(1 << (k % 5))});
            obs   = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            base  = (k < 4) ? 16'hFFFE : ((k < 9) ? 16'hFFFF : 16'h0000);
            exp_w = {1'b1, 3'(k % 5), 1'b0, 2'b00, (k == 9), base};
            n_tests++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL wrap step %0d: got %h want %h", k, obs, exp_w);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0]  stim [14] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h01, 7'h02, 7'h44,
                                   7'h08, 7'h10, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
        logic [23:0] expv [14] = '{
            {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd2, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd4, 1'b0, 2'b00, 1'b0, 16'd1},
            {1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 16'd1},
            {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 16'd1},
            {1'b0, 3'd7, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b0, 3'd3, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b0, 3'd4, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd2, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 16'd0},
            {1'b1, 3'd4, 1'b0, 2'b00, 1'b0, 16'd1}};
        logic [23:0] obs;
        for (int k = 0; k < 14; k++) begin
            step(stim[k]);
            obs = {bus.synced, bus.phase_idx, bus.err, bus.err_code, bus.retire_wrap, bus.retire_cnt};
            n_tests++;
            if (obs !== expv[k]) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h want %h", k, obs, expv[k]);
            end
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.clr_err = 1'b0;
        bus.IF      = 1'b0;
        bus.ID      = 1'b0;
        bus.EX      = 1'b0;
        bus.MEM     = 1'b0;
        bus.WB      = 1'b0;
        #1;
        test_reset();
        test_legal();
        test_out_of_order();
        test_multi_hot();
        test_clr_collision();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_checker.md
PHASE_CHECKER -- requirements
Module: phase_checker

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports IF, ID, EX, MEM, WB  input  1 each  phase strobes from the stage sequencer.
REQ-004 SHALL have port clr_err  input  1  one-cycle request to clear the error status.
REQ-005 SHALL have port phase_idx  output  3  encoded phase: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB, 7=invalid.
REQ-006 SHALL have port synced  output  1  checker is locked to the phase sequence.
REQ-007 SHALL have port retire_cnt  output  16  count of in-sequence WB phases.
REQ-008 SHALL have port retire_wrap  output  1  one-cycle pulse when retire_cnt wraps.
REQ-009 SHALL have port err  output  1  sticky error flag.
REQ-010 SHALL have port err_code  output  2  01=not one-hot, 10=out of order, 11=error while err already set.

Function
REQ-011 SHALL register all outputs; each output reflects the strobes sampled one cycle earlier.
REQ-012 SHALL set phase_idx to the index of the single asserted strobe, or 7 when zero or multiple strobes are asserted.
REQ-013 SHALL use a two-state FSM: HUNT (synced=0) and LOCK (synced=1).
REQ-014 In HUNT, SHALL move to LOCK on a cycle with IF alone asserted; all other vectors keep HUNT and raise no error.
REQ-015 In LOCK, SHALL set the expected phase to the successor of the last phase: IF->ID->EX->MEM->WB->IF.
REQ-016 In LOCK, SHALL flag code 01 on a zero-hot or multi-hot vector and return to HUNT.
REQ-017 In LOCK, SHALL flag code 10 on a one-hot vector that is not the expected phase, including a repeated phase, and return to HUNT.
REQ-018 When a new error is detected while err=1, SHALL set err_code to 11.
REQ-019 SHALL set err=1 on any error and hold it until clr_err or reset.
REQ-020 On clr_err with no new error in the same cycle, SHALL clear err and set err_code to 00 on the next cycle.
REQ-021 When clr_err and a new error occur in the same cycle, the new error SHALL win: err=1, err_code=01 or 10 as for a fresh error.
REQ-022 clr_err SHALL NOT affect synced, retire_cnt or the FSM state.
REQ-023 SHALL increment retire_cnt by 1 on an expected WB in LOCK; WB seen in HUNT or out of order SHALL NOT count.
REQ-024 retire_cnt SHALL wrap from 16'hFFFF to 0, and retire_wrap SHALL pulse in the same cycle the output wraps.
REQ-025 The IF that completes a legal WB->IF transition SHALL keep LOCK and SHALL NOT be treated as a new sync.

Reset
REQ-026 While reset=1 at a clock edge, SHALL force: state=HUNT, synced=0, phase_idx=7, retire_cnt=0, retire_wrap=0, err=0, err_code=00.
REQ-027 Reset asserted mid-sequence SHALL discard the expected phase; after release, the checker SHALL re-sync only on the next IF-alone cycle.
REQ-028 Strobes sampled during a reset cycle SHALL have no effect.

Structure
REQ-029 SHALL take from shared package phase_pkg: the phase enum (PH_IF=0 .. PH_WB=4, PH_NONE=7), the err_code constants, and the retire counter width parameter (16).
REQ-030 SHALL put one-hot validation and encoding in one combinational sub-module, onehot_enc (5-bit in, 3-bit index out, valid flag out).
REQ-031 The FSM, counter and error logic SHALL live in phase_checker.

Verification
REQ-032 Reset, then 3 legal IF..WB cycles -> synced=1 from the cycle after the first IF, retire_cnt=3, err=0, phase_idx follows 0,1,2,3,4.
REQ-033 In LOCK, drive ID then MEM (EX skipped) -> err=1, err_code=10, synced=0; later IF re-locks with retire_cnt unchanged.
REQ-034 In LOCK, drive IF+ID together -> phase_idx=7, err_code=01; a second error before clr_err -> err_code=11.
REQ-035 clr_err in the same cycle as an all-zero vector in LOCK -> err=1, err_code=01; clr_err alone on a later cycle -> err=0, err_code=00.
REQ-036 Preload retire_cnt to 16'hFFFE by sequencing, then 2 legal WB -> values 16'hFFFF then 0, with retire_wrap=1 for exactly one cycle.
REQ-037 Assert reset during EX -> all outputs at reset values; a following MEM or WB does not count; counting resumes only after IF.
